// File: rtl/filter_coef_pkg.sv
// Shared types and default coefficients for the IIR filter coefficient sequencer.
// Default set is a biquad in tap order n1,n2,n3,d1,d2.
package filter_coef_pkg;

   localparam int unsigned COEF_W_DEF = 32;
   localparam int unsigned FRAC_W_DEF = 16;
   localparam int unsigned DEF_N_TAPS = 5;

   typedef logic signed [COEF_W_DEF-1:0] coef_t;

   localparam coef_t N1_DEF = 32'h0000_7A3C;

   localparam coef_t DEF_COEF [DEF_N_TAPS] = '{
      N1_DEF,
      32'hFFFE_2EF4,
      32'h0000_E0F9,
      32'h0001_E339,
      32'hFFFF_1C99
   };

   // Taps beyond the default biquad set reset to zero.
   function automatic coef_t def_coef(input int unsigned tap);
      logic [2:0] k;
      k = tap[2:0];
      if (tap < DEF_N_TAPS) return DEF_COEF[k];
      return '0;
   endfunction

endpackage

// File: rtl/filter_coef_sequencer_bank.sv
// N_SETS x N_TAPS coefficient register array with one write port, one read mux
// and a whole-bank load; set 0 resets to the package defaults.
module coef_bank
   import filter_coef_pkg::*;
#(
   parameter int unsigned COEF_W = COEF_W_DEF,
   parameter int unsigned N_TAPS = DEF_N_TAPS,
   parameter int unsigned N_SETS = 4,
   localparam int unsigned SET_W = (N_SETS > 1) ? $clog2(N_SETS) : 1,
   localparam int unsigned TAP_W = $clog2(N_TAPS)
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    wr_en,
   input  logic [SET_W-1:0]                        wr_set,
   input  logic [TAP_W-1:0]                        wr_idx,
   input  logic [COEF_W-1:0]                       wr_data,
   input  logic                                    load_en,
   input  logic [N_SETS-1:0][N_TAPS-1:0][COEF_W-1:0] load_data,
   input  logic [SET_W-1:0]                        rd_set,
   input  logic [TAP_W-1:0]                        rd_idx,
   output logic [COEF_W-1:0]                       rd_data,
   output logic [N_SETS-1:0][N_TAPS-1:0][COEF_W-1:0] bank
);

   logic [N_SETS-1:0][N_TAPS-1:0][COEF_W-1:0] bank_q;
   logic [N_SETS-1:0][N_TAPS-1:0][COEF_W-1:0] bank_d;
   logic [N_SETS-1:0][N_TAPS-1:0][COEF_W-1:0] rst_bank;

   for (genvar t = 0; t < N_TAPS; t++) begin : g_rst_tap
      assign rst_bank[0][t] = COEF_W'(def_coef(t));
   end
   for (genvar s = 1; s < N_SETS; s++) begin : g_rst_set
      assign rst_bank[s] = '0;
   end

   always_comb begin
      bank_d = bank_q;
      if (load_en) begin
         bank_d = load_data;
      end else if (wr_en) begin
         bank_d[wr_set][wr_idx] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bank_q <= rst_bank;
      end else begin
         bank_q <= bank_d;
      end
   end

   assign rd_data = bank_q[rd_set][rd_idx];
   assign bank    = bank_q;

endmodule

// File: rtl/filter_coef_sequencer.sv
// Runtime-reloadable coefficient source: steps through the active set one tap per
// enable and commits the shadow bank to the active bank only at a wrap boundary.
module filter_coef_sequencer
   import filter_coef_pkg::*;
#(
   parameter int unsigned COEF_W = COEF_W_DEF,
   parameter int unsigned FRAC_W = FRAC_W_DEF,
   parameter int unsigned N_TAPS = DEF_N_TAPS,
   parameter int unsigned N_SETS = 4,
   localparam int unsigned SET_W = (N_SETS > 1) ? $clog2(N_SETS) : 1,
   localparam int unsigned TAP_W = $clog2(N_TAPS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [SET_W-1:0]  set_sel,
   input  logic              wr_en,
   input  logic [SET_W-1:0]  wr_set,
   input  logic [TAP_W-1:0]  wr_idx,
   input  logic [COEF_W-1:0] wr_data,
   input  logic              swap_req,
   output logic [COEF_W-1:0] coef_out,
   output logic [TAP_W-1:0]  tap_idx,
   output logic              first,
   output logic              last,
   output logic              swap_pending,
   output logic              swap_done,
   output logic              wr_err
);

   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

   logic [TAP_W-1:0] tap_q, tap_d;
   logic [SET_W-1:0] cur_set_q, cur_set_d;
   logic             swap_pending_q, swap_pending_d;
   logic             swap_done_q, swap_done_d;
   logic             wr_err_q, wr_err_d;

   logic wrap;
   logic commit;
   logic wr_ok;
   logic sel_ok;

   logic [N_SETS-1:0][N_TAPS-1:0][COEF_W-1:0] shadow_bank;
   logic [N_SETS-1:0][N_TAPS-1:0][COEF_W-1:0] active_bank_unused;
   logic [COEF_W-1:0]                         shadow_rd_unused;

   always_comb begin
      wrap   = enable && (tap_q == LAST_TAP);
      commit = wrap && swap_pending_q;
      wr_ok  = wr_en && (32'(wr_set) < N_SETS) && (32'(wr_idx) < N_TAPS);
      sel_ok = (32'(set_sel) < N_SETS);
   end

   always_comb begin
      tap_d          = tap_q;
      cur_set_d      = cur_set_q;
      swap_pending_d = swap_pending_q;
      if (enable) begin
         tap_d = wrap ? '0 : tap_q + TAP_W'(1);
      end
      if (wrap && sel_ok) begin
         cur_set_d = set_sel;
      end
      // A request landing on the committing edge re-arms for the next wrap.
      if (commit) begin
         swap_pending_d = swap_req;
      end else if (swap_req) begin
         swap_pending_d = 1'b1;
      end
      swap_done_d = commit;
      wr_err_d    = wr_en && !wr_ok;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tap_q          <= '0;
         cur_set_q      <= '0;
         swap_pending_q <= 1'b0;
         swap_done_q    <= 1'b0;
         wr_err_q       <= 1'b0;
      end else begin
         tap_q          <= tap_d;
         cur_set_q      <= cur_set_d;
         swap_pending_q <= swap_pending_d;
         swap_done_q    <= swap_done_d;
         wr_err_q       <= wr_err_d;
      end
   end

   coef_bank #(
      .COEF_W (COEF_W),
      .N_TAPS (N_TAPS),
      .N_SETS (N_SETS)
   ) u_shadow (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_ok),
      .wr_set    (wr_set),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .load_en   (1'b0),
      .load_data ('0),
      .rd_set    ('0),
      .rd_idx    ('0),
      .rd_data   (shadow_rd_unused),
      .bank      (shadow_bank)
   );

   // The active bank only ever changes by a whole-bank copy of the pre-edge shadow.
   coef_bank #(
      .COEF_W (COEF_W),
      .N_TAPS (N_TAPS),
      .N_SETS (N_SETS)
   ) u_active (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (1'b0),
      .wr_set    ('0),
      .wr_idx    ('0),
      .wr_data   ('0),
      .load_en   (commit),
      .load_data (shadow_bank),
      .rd_set    (cur_set_q),
      .rd_idx    (tap_q),
      .rd_data   (coef_out),
      .bank      (active_bank_unused)
   );

   assign tap_idx      = tap_q;
   assign first        = (tap_q == '0);
   assign last         = (tap_q == LAST_TAP);
   assign swap_pending = swap_pending_q;
   assign swap_done    = swap_done_q;
   assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_filter_coef_sequencer.sv
// Directed bench for filter_coef_sequencer: stepping, shadow writes, swap timing,
// set selection, write range errors and reset during a pending commit.
module tb_filter_coef_sequencer;

   localparam logic [31:0] N1   = 32'h0000_7A3C;
   localparam logic [31:0] N2   = 32'hFFFE_2EF4;
   localparam logic [31:0] N3   = 32'h0000_E0F9;
   localparam logic [31:0] D1   = 32'h0001_E339;
   localparam logic [31:0] D2   = 32'hFFFF_1C99;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [1:0]  set_sel;
   logic        wr_en;
   logic [1:0]  wr_set;
   logic [2:0]  wr_idx;
   logic [31:0] wr_data;
   logic        swap_req;
   logic [31:0] coef_out;
   logic [2:0]  tap_idx;
   logic        first;
   logic        last;
   logic        swap_pending;
   logic        swap_done;
   logic        wr_err;

   int unsigned total = 0;
   int unsigned bad   = 0;

   logic [31:0] exp_seq [6];

   always #5 clk = ~clk;

   filter_coef_sequencer #(
      .COEF_W (32),
      .FRAC_W (16),
      .N_TAPS (5),
      .N_SETS (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .set_sel      (set_sel),
      .wr_en        (wr_en),
      .wr_set       (wr_set),
      .wr_idx       (wr_idx),
      .wr_data      (wr_data),
      .swap_req     (swap_req),
      .coef_out     (coef_out),
      .tap_idx      (tap_idx),
      .first        (first),
      .last         (last),
      .swap_pending (swap_pending),
      .swap_done    (swap_done),
      .wr_err       (wr_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         enable = 1'b1;
         tick();
      end
      enable = 1'b0;
   endtask

   initial begin
      exp_seq = '{N1, N2, N3, D1, D2, N1};
      reset = 1'b1; enable = 1'b0; set_sel = '0; wr_en = 1'b0;
      wr_set = '0; wr_idx = '0; wr_data = '0; swap_req = 1'b0;
      tick(); tick();
      reset = 1'b0;

      check("rst_coef",    coef_out,     N1);
      check("rst_tap",     32'(tap_idx), 32'd0);
      check("rst_first",   32'(first),   32'd1);
      check("rst_last",    32'(last),    32'd0);
      check("rst_pending", 32'(swap_pending), 32'd0);
      check("rst_done",    32'(swap_done),    32'd0);
      check("rst_err",     32'(wr_err),       32'd0);

      for (int i = 0; i < 6; i++) begin
         check($sformatf("seq_coef%0d", i), coef_out, exp_seq[i]);
         check($sformatf("seq_first%0d", i), 32'(first), 32'((i == 0) || (i == 5)));
         check($sformatf("seq_last%0d", i), 32'(last), 32'(i == 4));
         step(1);
      end
      check("seq_tap_after", 32'(tap_idx), 32'd1);

      // shadow write then swap request at tap 2
      wr_en = 1'b1; wr_set = 2'd0; wr_idx = 3'd1; wr_data = 32'h1234_5678;
      tick();
      wr_en = 1'b0;
      check("wr_ok_err", 32'(wr_err), 32'd0);
      check("wr_active_untouched", coef_out, N2);
      step(1);
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      check("swap_pending_set", 32'(swap_pending), 32'd1);
      check("swap_tap2_coef", coef_out, N3);
      step(2);
      check("swap_tap4_pending", 32'(swap_pending), 32'd1);
      check("swap_tap4_done", 32'(swap_done), 32'd0);
      check("swap_tap4_coef", coef_out, D2);
      step(1);
      check("swap_done_pulse", 32'(swap_done), 32'd1);
      check("swap_pending_clr", 32'(swap_pending), 32'd0);
      check("swap_wrap_coef", coef_out, N1);
      tick();
      check("swap_done_once", 32'(swap_done), 32'd0);
      step(1);
      check("swap_new_tap1", coef_out, 32'h1234_5678);

      // swap_req and write on the commit edge
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      check("edge_pending", 32'(swap_pending), 32'd1);
      step(3);
      enable = 1'b1; swap_req = 1'b1;
      wr_en = 1'b1; wr_set = 2'd0; wr_idx = 3'd2; wr_data = 32'hAAAA_5555;
      tick();
      enable = 1'b0; swap_req = 1'b0; wr_en = 1'b0;
      check("edge_done", 32'(swap_done), 32'd1);
      check("edge_rearm", 32'(swap_pending), 32'd1);
      check("edge_tap0", 32'(tap_idx), 32'd0);
      step(2);
      check("edge_excluded", coef_out, N3);
      step(3);
      check("edge_done2", 32'(swap_done), 32'd1);
      check("edge_pending2", 32'(swap_pending), 32'd0);
      step(2);
      check("edge_included", coef_out, 32'hAAAA_5555);

      // set select changed mid-pass
      step(4);
      check("sel_tap1_set0", coef_out, 32'h1234_5678);
      set_sel = 2'd2;
      step(1);
      check("sel_hold_set0", coef_out, 32'hAAAA_5555);
      step(3);
      check("sel_set2_tap0", coef_out, 32'd0);
      check("sel_set2_first", 32'(first), 32'd1);
      step(1);
      check("sel_set2_tap1", coef_out, 32'd0);

      // out-of-range tap index write
      wr_en = 1'b1; wr_set = 2'd2; wr_idx = 3'd5; wr_data = 32'hDEAD_BEEF;
      tick();
      wr_en = 1'b0;
      check("err_pulse", 32'(wr_err), 32'd1);
      tick();
      check("err_clear", 32'(wr_err), 32'd0);
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      step(4);
      check("err_commit", 32'(swap_done), 32'd1);
      for (int t = 0; t < 5; t++) begin
         check($sformatf("err_set2_tap%0d", t), coef_out, 32'd0);
         step(1);
      end

      // reset with a commit pending at tap 3
      set_sel = 2'd0;
      wr_en = 1'b1; wr_set = 2'd0; wr_idx = 3'd0; wr_data = 32'h1111_2222;
      swap_req = 1'b1;
      tick();
      wr_en = 1'b0; swap_req = 1'b0;
      check("rr_pending", 32'(swap_pending), 32'd1);
      step(3);
      check("rr_tap3", 32'(tap_idx), 32'd3);
      reset = 1'b1; tick(); reset = 1'b0;
      check("rr_tap", 32'(tap_idx), 32'd0);
      check("rr_pending_clr", 32'(swap_pending), 32'd0);
      check("rr_coef", coef_out, N1);
      check("rr_done", 32'(swap_done), 32'd0);
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      step(5);
      check("rr_commit", 32'(swap_done), 32'd1);
      check("rr_shadow_tap0", coef_out, N1);
      step(1);
      check("rr_shadow_tap1", coef_out, N2);
      step(1);
      check("rr_shadow_tap2", coef_out, N3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
